// File: rtl/bus_reg_pkg.sv
// Shared definitions for bus_reg_decoder: the decoder FSM states and the
// index-width helper used to size beat and register selectors.
package bus_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_COMMIT   = 2'd2
  } state_e;

  // A selector needs at least one bit even when there is only one choice.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_reg_assembler.sv
// Shadow buffer, expected-beat counter and mid-assembly idle timer for
// bus_reg_decoder. All sequencing decisions are made by the parent.
module bus_reg_assembler
  import bus_reg_pkg::*;
#(
  parameter int BEAT_W        = 8,
  parameter int BEATS_PER_REG = 4,
  parameter int TIMEOUT       = 255,
  localparam int BIDX_W       = idx_w(BEATS_PER_REG),
  localparam int REG_W        = BEAT_W * BEATS_PER_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_first,
  input  logic              load_next,
  input  logic              clear,
  input  logic              tick_en,
  input  logic              accepted,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [REG_W-1:0]  shadow,
  output logic [BIDX_W-1:0] expected,
  output logic              timeout
);

  localparam int CNT_W = idx_w(TIMEOUT + 1);

  logic [BEATS_PER_REG-1:0][BEAT_W-1:0] shadow_q, shadow_d;
  logic [BIDX_W-1:0]                    expected_q, expected_d;
  logic [CNT_W-1:0]                     idle_cnt_q, idle_cnt_d;

  always_comb begin
    shadow_d   = shadow_q;
    expected_d = expected_q;
    if (clear) begin
      shadow_d   = '0;
      expected_d = '0;
    end else if (load_first) begin
      shadow_d    = '0;
      shadow_d[0] = beat_data;
      expected_d  = BIDX_W'(1);
    end else if (load_next) begin
      for (int b = 0; b < BEATS_PER_REG; b++) begin
        if (int'(expected_q) == b) shadow_d[b] = beat_data;
      end
      expected_d = expected_q + 1'b1;
    end
  end

  // Counts only silent cycles while assembling; any accepted beat restarts it.
  always_comb begin
    idle_cnt_d = '0;
    if (tick_en && !accepted) idle_cnt_d = idle_cnt_q + 1'b1;
  end

  assign timeout = (TIMEOUT != 0) && tick_en && !accepted &&
                   (int'(idle_cnt_q) + 1 == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      expected_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      expected_q <= expected_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign shadow   = shadow_q;
  assign expected = expected_q;

endmodule

// File: rtl/bus_reg_decoder.sv
// Multi-beat register write decoder with atomic per-register commit.
// Optional readback port enabled by defining BUS_REG_DECODER_RDBK_EN.
module bus_reg_decoder
  import bus_reg_pkg::*;
#(
  parameter int ADDR_W        = 6,
  parameter int BEAT_W        = 8,
  parameter int NUM_REGS      = 4,
  parameter int BEATS_PER_REG = 4,
  parameter logic [NUM_REGS*BEAT_W*BEATS_PER_REG-1:0] RESET_VAL = '0,
  parameter int TIMEOUT       = 255,
  localparam int REG_W        = BEAT_W * BEATS_PER_REG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [BEAT_W-1:0]         in_data,
`ifdef BUS_REG_DECODER_RDBK_EN
  input  logic [idx_w(NUM_REGS)-1:0] rd_sel,
  output logic [REG_W-1:0]          rd_data,
`endif
  output logic [NUM_REGS*REG_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]       reg_stb,
  output logic                      seq_err,
  output logic                      addr_err,
  output logic                      busy
);

  localparam int BIDX_W   = idx_w(BEATS_PER_REG);
  localparam int RIDX_W   = idx_w(NUM_REGS);
  localparam int MAP_SIZE = NUM_REGS * BEATS_PER_REG;
  localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(BEATS_PER_REG - 1);

  state_e                     state_q, state_d;
  logic [RIDX_W-1:0]          cur_reg_q, cur_reg_d;
  logic [NUM_REGS*REG_W-1:0]  reg_out_q, reg_out_d;
  logic [NUM_REGS-1:0]        reg_stb_q, reg_stb_d;
  logic                       seq_err_q, seq_err_d;
  logic                       addr_err_q, addr_err_d;

  logic                       accept, in_map, timeout;
  logic                       load_first, load_next, clear_shadow;
  logic [RIDX_W-1:0]          beat_reg;
  logic [BIDX_W-1:0]          beat_idx;
  logic [REG_W-1:0]           shadow;
  logic [BIDX_W-1:0]          expected;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q != ST_COMMIT);
  assign accept   = in_valid && in_ready;
  assign in_map   = int'(in_addr) < MAP_SIZE;
  assign beat_reg = RIDX_W'(int'(in_addr) / BEATS_PER_REG);
  assign beat_idx = BIDX_W'(int'(in_addr) % BEATS_PER_REG);

  bus_reg_assembler #(
    .BEAT_W        (BEAT_W),
    .BEATS_PER_REG (BEATS_PER_REG),
    .TIMEOUT       (TIMEOUT)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .load_first (load_first),
    .load_next  (load_next),
    .clear      (clear_shadow),
    .tick_en    (state_q == ST_ASSEMBLE),
    .accepted   (accept),
    .beat_data  (in_data),
    .shadow     (shadow),
    .expected   (expected),
    .timeout    (timeout)
  );

  always_comb begin
    state_d      = state_q;
    cur_reg_d    = cur_reg_q;
    reg_out_d    = reg_out_q;
    reg_stb_d    = '0;
    seq_err_d    = 1'b0;
    addr_err_d   = 1'b0;
    load_first   = 1'b0;
    load_next    = 1'b0;
    clear_shadow = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_map) begin
            addr_err_d = 1'b1;
          end else if (beat_idx == '0) begin
            cur_reg_d  = beat_reg;
            load_first = 1'b1;
            state_d    = (BEATS_PER_REG == 1) ? ST_COMMIT : ST_ASSEMBLE;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      ST_ASSEMBLE: begin
        if (accept) begin
          if (!in_map) begin
            addr_err_d = 1'b1;
          end else if (beat_reg == cur_reg_q && beat_idx == expected) begin
            load_next = 1'b1;
            if (expected == LAST_BEAT) state_d = ST_COMMIT;
          end else begin
            seq_err_d = 1'b1;
            if (beat_idx == '0) begin
              cur_reg_d  = beat_reg;
              load_first = 1'b1;
            end else begin
              clear_shadow = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end else if (timeout) begin
          seq_err_d    = 1'b1;
          clear_shadow = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        for (int r = 0; r < NUM_REGS; r++) begin
          if (int'(cur_reg_q) == r) begin
            reg_out_d[r*REG_W +: REG_W] = shadow;
            reg_stb_d[r]                = 1'b1;
          end
        end
        clear_shadow = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_reg_q  <= '0;
      reg_out_q  <= RESET_VAL;
      reg_stb_q  <= '0;
      seq_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_reg_q  <= cur_reg_d;
      reg_out_q  <= reg_out_d;
      reg_stb_q  <= reg_stb_d;
      seq_err_q  <= seq_err_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign reg_out  = reg_out_q;
  assign reg_stb  = reg_stb_q;
  assign seq_err  = seq_err_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef BUS_REG_DECODER_RDBK_EN
  logic [REG_W-1:0] rd_data_q, rd_data_d;

  // Reads the pre-edge bank, so a same-cycle commit returns the old value.
  always_comb begin
    rd_data_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (int'(rd_sel) == r) rd_data_d = reg_out_q[r*REG_W +: REG_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

endmodule
